// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the multiply opcode.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  localparam op_t MUL_OP = OP_MUL;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-read stage, the ALU and write-back.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, negative, overflow, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, negative, overflow, busy
  );
endinterface

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks per multiply.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic               r_run;

  logic               w_last;
  logic [2*WIDTH-1:0] w_acc_next;

  // The final iteration's sum is exposed combinationally so the parent can register it on that same edge.
  assign w_last     = r_run && (r_count == CW'(WIDTH - 1));
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign o_done     = w_last;
  assign o_product  = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_count  <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
      if (w_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU between register read and write-back: single-cycle ops plus an iterative multiply,
// with the result and flags held until the downstream stage takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_next_state;

  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_carry;
  logic               r_negative;
  logic               r_overflow;

  logic               w_accept;
  op_t                w_op;
  logic               w_start;
  logic               w_load;
  logic [WIDTH-1:0]   w_ld_result;
  logic               w_ld_carry;
  logic               w_ld_overflow;

  logic [WIDTH-1:0]   w_alu_result;
  logic               w_alu_carry;
  logic               w_alu_overflow;
  logic [WIDTH:0]     w_sum;

  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_product;

  assign w_op         = op_t'(bus.op);
  assign bus.in_ready = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_comb begin
    w_sum          = '0;
    w_alu_result   = '0;
    w_alu_carry    = 1'b0;
    w_alu_overflow = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_sum          = {1'b0, bus.a} + {1'b0, bus.b};
        w_alu_result   = w_sum[WIDTH-1:0];
        w_alu_carry    = w_sum[WIDTH];
        w_alu_overflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      // The extra top bit of a zero-extended subtract is the unsigned borrow.
      OP_SUB: begin
        w_sum          = {1'b0, bus.a} - {1'b0, bus.b};
        w_alu_result   = w_sum[WIDTH-1:0];
        w_alu_carry    = w_sum[WIDTH];
        w_alu_overflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  w_alu_result = bus.a & bus.b;
      OP_OR:   w_alu_result = bus.a | bus.b;
      OP_XOR:  w_alu_result = bus.a ^ bus.b;
      OP_SHL:  w_alu_result = bus.a << bus.b[SHW-1:0];
      OP_SHR:  w_alu_result = bus.a >> bus.b[SHW-1:0];
      default: w_alu_result = '0;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    w_start       = 1'b0;
    w_load        = 1'b0;
    w_ld_result   = w_alu_result;
    w_ld_carry    = w_alu_carry;
    w_ld_overflow = w_alu_overflow;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_accept) begin
          if (w_op == MUL_OP) begin
            w_start      = 1'b1;
            w_next_state = ST_MUL;
          end else begin
            w_load       = 1'b1;
            w_next_state = ST_HOLD;
          end
        end else if ((r_state == ST_HOLD) && bus.out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_load        = 1'b1;
          w_ld_result   = w_mul_product[WIDTH-1:0];
          w_ld_carry    = |w_mul_product[2*WIDTH-1:WIDTH];
          w_ld_overflow = 1'b0;
          w_next_state  = ST_HOLD;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Result and flags change only on a load, so they stay stable through HOLD and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_load) begin
      r_result   <= w_ld_result;
      r_zero     <= (w_ld_result == '0);
      r_carry    <= w_ld_carry;
      r_negative <= w_ld_result[WIDTH-1];
      r_overflow <= w_ld_overflow;
    end
  end

  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.busy      = (r_state == ST_MUL);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.negative  = r_negative;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq: a table of single ops plus backpressure and mid-multiply reset sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 40;

  typedef struct {
    op_t        op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expResult;
    logic [3:0] expFlags;
    int         expLatency;
  } vector_t;

  logic clk = 1'b0;
  logic rst_n;

  int numVectors     = 0;
  int numMiscompares = 0;

  vector_t vecs[15];

  alu_seq_if #(.WIDTH(WIDTH)) bus();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] flagsNow();
    return {bus.zero, bus.carry, bus.negative, bus.overflow};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numVectors++;
    if (actual !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one op, scrambles the operands after the accept edge, then waits (bounded) for out_valid.
  task automatic applyStimulus(input op_t op, input logic [7:0] a, input logic [7:0] b,
                               output int latency, output int busyCycles, output bit ok);
    int waited;
    latency    = 0;
    busyCycles = 0;
    ok         = 1'b1;
    waited     = 0;
    @(negedge clk);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = ~b;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.busy) busyCycles++;
      latency++;
      if (latency > TIMEOUT) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    int  busyCnt;
    bit  ok;

    vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100, 0};
    vecs[1]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001, 0};
    vecs[2]  = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b0110, 0};
    vecs[3]  = '{OP_MUL, 8'h0D, 8'h0B, 8'h8F, 4'b0010, 8};
    vecs[4]  = '{OP_MUL, 8'h10, 8'h10, 8'h00, 4'b1100, 8};
    vecs[5]  = '{OP_SHL, 8'h01, 8'h0B, 8'h08, 4'b0000, 0};
    vecs[6]  = '{OP_SHR, 8'h80, 8'h07, 8'h01, 4'b0000, 0};
    vecs[7]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 0};
    vecs[8]  = '{OP_OR,  8'h00, 8'h00, 8'h00, 4'b1000, 0};
    vecs[9]  = '{OP_XOR, 8'h0F, 8'hF0, 8'hFF, 4'b0010, 0};
    vecs[10] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0011, 0};
    vecs[11] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 4'b0100, 8};
    vecs[12] = '{OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0000, 0};
    vecs[13] = '{OP_SUB, 8'h05, 8'h05, 8'h00, 4'b1000, 0};
    vecs[14] = '{OP_OR,  8'hA0, 8'h05, 8'hA5, 4'b0010, 0};

    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    #1;
    checkOutput("reset result", 32'(bus.result), 32'h0);
    checkOutput("reset flags", 32'(flagsNow()), 32'h0);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset busy", 32'(bus.busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'h1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyCnt, ok);
      checkOutput($sformatf("vec%0d handshake", i), 32'(ok), 32'h1);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLatency));
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyCnt), 32'(vecs[i].expLatency));
      checkOutput($sformatf("vec%0d result", i), 32'(bus.result), 32'(vecs[i].expResult));
      checkOutput($sformatf("vec%0d flags", i), 32'(flagsNow()), 32'(vecs[i].expFlags));
      consume();
      @(negedge clk);
      checkOutput($sformatf("vec%0d out_valid drop", i), 32'(bus.out_valid), 32'h0);
    end

    // Backpressure: result held while out_ready is low, then a back-to-back XOR on release.
    applyStimulus(OP_ADD, 8'h12, 8'h34, lat, busyCnt, ok);
    checkOutput("bp handshake", 32'(ok), 32'h1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp hold%0d result", k), 32'(bus.result), 32'h46);
      checkOutput($sformatf("bp hold%0d flags", k), 32'(flagsNow()), 32'h0);
      checkOutput($sformatf("bp hold%0d in_ready", k), 32'(bus.in_ready), 32'h0);
      checkOutput($sformatf("bp hold%0d out_valid", k), 32'(bus.out_valid), 32'h1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = OP_XOR;
    bus.a         = 8'hAA;
    bus.b         = 8'hFF;
    #1;
    checkOutput("bp release in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp b2b out_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("bp b2b result", 32'(bus.result), 32'h55);
    checkOutput("bp b2b flags", 32'(flagsNow()), 32'h0);
    consume();

    // Reset during the fourth multiply cycle clears outputs without waiting for a clock.
    @(negedge clk);
    bus.op       = OP_MUL;
    bus.a        = 8'h0D;
    bus.b        = 8'h0B;
    bus.in_valid = 1'b1;
    checkOutput("mulrst in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("mulrst busy before", 32'(bus.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mulrst result", 32'(bus.result), 32'h0);
    checkOutput("mulrst flags", 32'(flagsNow()), 32'h0);
    checkOutput("mulrst busy", 32'(bus.busy), 32'h0);
    checkOutput("mulrst out_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mulrst release in_ready", 32'(bus.in_ready), 32'h1);
    repeat (10) @(negedge clk);
    checkOutput("mulrst no stale output", 32'(bus.out_valid), 32'h0);
    applyStimulus(OP_ADD, 8'h05, 8'h03, lat, busyCnt, ok);
    checkOutput("mulrst add handshake", 32'(ok), 32'h1);
    checkOutput("mulrst add latency", 32'(lat), 32'h0);
    checkOutput("mulrst add result", 32'(bus.result), 32'h08);
    checkOutput("mulrst add flags", 32'(flagsNow()), 32'h0);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
